// File: rtl/x_stack.sv
// LIFO stack beside the CPU: top word held in its own register, lower words in a body array.
// All outputs are registered; push/pop/replace/clear resolved in one next-state block.
module x_stack #(
    parameter  int X_SIZE = 1024,
    parameter  int DEPTH  = 16,
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              clear_in,
    input  logic [X_SIZE-1:0] push_data_in,
    input  logic              push_valid_in,
    output logic              push_ready_out,
    output logic [X_SIZE-1:0] top_out,
    output logic              top_valid_out,
    input  logic              pop_ready_in,
    output logic [CW-1:0]     count_out,
    output logic              overflow_out,
    output logic              underflow_out
);

    localparam int AW = (DEPTH - 1 > 1) ? $clog2(DEPTH - 1) : 1;

    logic [X_SIZE-1:0] mem_r [DEPTH-1];
    logic [X_SIZE-1:0] top_r;
    logic [CW-1:0]     count_r;
    logic              push_ready_r;
    logic              top_valid_r;
    logic              overflow_r;
    logic              underflow_r;

    logic [X_SIZE-1:0] top_nxt_s;
    logic [CW-1:0]     count_nxt_s;
    logic              overflow_nxt_s;
    logic              underflow_nxt_s;
    logic              mem_we_s;
    logic              full_s;
    logic              empty_s;
    logic              push_fire_s;
    logic              pop_fire_s;
    logic [CW-1:0]     wr_idx_s;
    logic [CW-1:0]     rd_idx_s;

    assign full_s      = (count_r == CW'(DEPTH));
    assign empty_s     = (count_r == {CW{1'b0}});
    assign push_fire_s = push_valid_in & push_ready_r;
    assign pop_fire_s  = pop_ready_in & top_valid_r;
    // Old top spills to slot count-1; the word below the top lives at count-2.
    assign wr_idx_s    = count_r - CW'(1);
    assign rd_idx_s    = count_r - CW'(2);

    // Next-state decode: clear first, then the push/pop case table and sticky flags.
    always_comb begin
        top_nxt_s       = top_r;
        count_nxt_s     = count_r;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        mem_we_s        = 1'b0;
        if (clear_in) begin
            top_nxt_s       = {X_SIZE{1'b0}};
            count_nxt_s     = {CW{1'b0}};
            overflow_nxt_s  = 1'b0;
            underflow_nxt_s = 1'b0;
        end else begin
            if (push_valid_in && full_s) begin
                overflow_nxt_s = 1'b1;
            end else begin
                overflow_nxt_s = overflow_r;
            end
            if (pop_ready_in && empty_s) begin
                underflow_nxt_s = 1'b1;
            end else begin
                underflow_nxt_s = underflow_r;
            end
            case ({push_fire_s, pop_fire_s})
                2'b10: begin
                    mem_we_s    = !empty_s;
                    top_nxt_s   = push_data_in;
                    count_nxt_s = count_r + CW'(1);
                end
                2'b01: begin
                    if (count_r >= CW'(2)) begin
                        top_nxt_s = mem_r[rd_idx_s[AW-1:0]];
                    end else begin
                        top_nxt_s = {X_SIZE{1'b0}};
                    end
                    count_nxt_s = count_r - CW'(1);
                end
                2'b11: begin
                    top_nxt_s = push_data_in;
                end
                default: begin
                    top_nxt_s = top_r;
                end
            endcase
        end
    end

    // Control state and registered handshake outputs.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            top_r        <= {X_SIZE{1'b0}};
            count_r      <= {CW{1'b0}};
            push_ready_r <= 1'b1;
            top_valid_r  <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            top_r        <= top_nxt_s;
            count_r      <= count_nxt_s;
            push_ready_r <= (count_nxt_s != CW'(DEPTH));
            top_valid_r  <= (count_nxt_s != {CW{1'b0}});
            overflow_r   <= overflow_nxt_s;
            underflow_r  <= underflow_nxt_s;
        end
    end

    // Body array write; contents are don't-care until written, so no reset.
    always_ff @(posedge clk_in) begin
        if (mem_we_s) begin
            mem_r[wr_idx_s[AW-1:0]] <= top_r;
        end
    end

    assign top_out        = top_r;
    assign count_out      = count_r;
    assign push_ready_out = push_ready_r;
    assign top_valid_out  = top_valid_r;
    assign overflow_out   = overflow_r;
    assign underflow_out  = underflow_r;

endmodule

// File: tb/tb_x_stack.sv
// Directed bench for x_stack: push/pop ordering, overflow, replace, underflow, clear, async reset.
module tb_x_stack;

    localparam int X_SIZE = 1024;
    localparam int DEPTH  = 16;
    localparam int CW     = $clog2(DEPTH + 1);

    logic              clk_in;
    logic              rst_in;
    logic              clear_in;
    logic [X_SIZE-1:0] push_data_in;
    logic              push_valid_in;
    logic              push_ready_out;
    logic [X_SIZE-1:0] top_out;
    logic              top_valid_out;
    logic              pop_ready_in;
    logic [CW-1:0]     count_out;
    logic              overflow_out;
    logic              underflow_out;

    int n_checks;
    int n_errors;

    x_stack #(.X_SIZE(X_SIZE), .DEPTH(DEPTH)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .clear_in      (clear_in),
        .push_data_in  (push_data_in),
        .push_valid_in (push_valid_in),
        .push_ready_out(push_ready_out),
        .top_out       (top_out),
        .top_valid_out (top_valid_out),
        .pop_ready_in  (pop_ready_in),
        .count_out     (count_out),
        .overflow_out  (overflow_out),
        .underflow_out (underflow_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [X_SIZE-1:0] got, input logic [X_SIZE-1:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got[63:0], exp[63:0]);
        end
    endtask

    // One clock cycle with the given inputs, then return all inputs idle at edge+1.
    task automatic cyc(input logic pv, input logic [X_SIZE-1:0] d, input logic pr, input logic clr);
        push_valid_in = pv;
        push_data_in  = d;
        pop_ready_in  = pr;
        clear_in      = clr;
        @(posedge clk_in);
        #1;
        push_valid_in = 1'b0;
        push_data_in  = '0;
        pop_ready_in  = 1'b0;
        clear_in      = 1'b0;
    endtask

    task automatic push(input logic [X_SIZE-1:0] d);
        cyc(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cyc(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic clr();
        cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_top"},   top_out,        '0);
        check({tag, "_valid"}, top_valid_out,  '0);
        check({tag, "_ready"}, push_ready_out, 1);
        check({tag, "_count"}, count_out,      '0);
        check({tag, "_ovf"},   overflow_out,   '0);
        check({tag, "_unf"},   underflow_out,  '0);
    endtask

    logic [X_SIZE-1:0] exp_pop [3];

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_in        = 1'b0;
        clear_in      = 1'b0;
        push_valid_in = 1'b0;
        push_data_in  = '0;
        pop_ready_in  = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_idle_outputs("reset");
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;

        // Push three, pop three; top seen during the pop cycle itself.
        push(X_SIZE'(32'hA));
        push(X_SIZE'(32'hB));
        push(X_SIZE'(32'hC));
        check("p3_count", count_out, 3);
        check("p3_top",   top_out,   X_SIZE'(32'hC));
        exp_pop[0] = X_SIZE'(32'hC);
        exp_pop[1] = X_SIZE'(32'hB);
        exp_pop[2] = X_SIZE'(32'hA);
        for (int i = 0; i < 3; i++) begin
            pop_ready_in = 1'b1;
            #1;
            check($sformatf("pop%0d_top", i), top_out, exp_pop[i]);
            cyc(1'b0, '0, 1'b1, 1'b0);
        end
        check("p3_after_top",   top_out,       '0);
        check("p3_after_valid", top_valid_out, '0);
        check("p3_after_unf",   underflow_out, '0);
        check("p3_after_count", count_out,     '0);

        // Fill to DEPTH, then a dropped push while full.
        for (int i = 1; i <= DEPTH; i++) begin
            push(X_SIZE'(i));
        end
        check("full_count", count_out,      16);
        check("full_ready", push_ready_out, 0);
        check("full_top",   top_out,        16);
        push(X_SIZE'(17));
        check("ovf_flag",  overflow_out, 1);
        check("ovf_top",   top_out,      16);
        check("ovf_count", count_out,    16);
        pop();
        check("ovf_pop_ready", push_ready_out, 1);
        check("ovf_pop_top",   top_out,        15);
        check("ovf_pop_count", count_out,      15);
        pop();
        check("ovf_pop2_top",  top_out,        14);
        check("ovf_sticky",    overflow_out,   1);
        clr();
        check_idle_outputs("clr1");

        // Replace: push and pop together on [5,6].
        push(X_SIZE'(5));
        push(X_SIZE'(6));
        cyc(1'b1, X_SIZE'(9), 1'b1, 1'b0);
        check("rep_count", count_out, 2);
        check("rep_top",   top_out,   9);
        pop();
        check("rep_pop_top",   top_out,   5);
        check("rep_pop_count", count_out, 1);
        clr();

        // Underflow, then push+pop on empty: push wins.
        pop();
        check("unf_flag",  underflow_out, 1);
        check("unf_count", count_out,     0);
        check("unf_valid", top_valid_out, 0);
        cyc(1'b1, X_SIZE'(7), 1'b1, 1'b0);
        check("unf_push_count", count_out,     1);
        check("unf_push_top",   top_out,       7);
        check("unf_push_valid", top_valid_out, 1);
        check("unf_sticky",     underflow_out, 1);

        // Clear outranks a simultaneous push; also wipes the sticky flag.
        clr();
        push(X_SIZE'(1));
        push(X_SIZE'(2));
        push(X_SIZE'(3));
        pop_ready_in = 1'b0;
        cyc(1'b1, X_SIZE'(4), 1'b0, 1'b1);
        check_idle_outputs("clr_pri");

        // Async reset between edges with count=5.
        for (int i = 0; i < 5; i++) begin
            push(X_SIZE'(32'h100 + i));
        end
        check("pre_rst_count", count_out, 5);
        #2;
        rst_in = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk_in);
        rst_in = 1'b1;
        @(posedge clk_in);
        #1;
        push(X_SIZE'(32'h55));
        check("post_rst_top",   top_out,   X_SIZE'(32'h55));
        check("post_rst_count", count_out, 1);
        push({X_SIZE/32{32'hDEADBEEF}});
        check("wide_top", top_out, {X_SIZE/32{32'hDEADBEEF}});
        pop();
        check("wide_pop_top", top_out, X_SIZE'(32'h55));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/x_stack.md
# x_stack

Hardware LIFO stack serving the CPU's PUSH X / PUSH Y / POP X / POP Y instructions. It holds up to DEPTH words of X_SIZE bits. The top entry sits in a dedicated register so the top-of-stack output never passes through a memory read mux. It sits directly beside the cpu block: the CPU's stack output feeds push_data_in, and top_out feeds the CPU's stack input.

## Interface
- X_SIZE, 1024, width of one stack word (matches CPU X/Y registers)
- DEPTH, 16, maximum number of stored words; must be >= 2
- CW (local), $clog2(DEPTH+1), width of count_out
- clk_in  input  1  system clock, all state on rising edge
- rst_in  input  1  asynchronous, active-low reset
- clear_in  input  1  synchronous flush: empty the stack, clear flags
- push_data_in  input  X_SIZE  word to push (from CPU stack_out)
- push_valid_in  input  1  CPU wants to push (from CPU stack_out_valid)
- push_ready_out  output  1  stack can accept a push (to CPU stack_out_ready)
- top_out  output  X_SIZE  current top word (to CPU stack_in)
- top_valid_out  output  1  stack non-empty, top_out meaningful (to CPU stack_in_valid)
- pop_ready_in  input  1  CPU consumes top this cycle (from CPU stack_in_ready)
- count_out  output  CW  number of stored words, 0..DEPTH
- overflow_out  output  1  sticky: a push was attempted while full
- underflow_out  output  1  sticky: a pop was attempted while empty

## Operation
- State: top register `top` (X_SIZE), body array `mem[0..DEPTH-2]`, counter `count`, two sticky flags. The body array is not reset. Only `count`, `top` and the flags are reset.
- Derived signals, all from registers only:
  - empty = (count==0), full = (count==DEPTH)
  - push_ready_out = !full
  - top_valid_out = !empty
  - top_out = top
  - count_out = count
- push_fire = push_valid_in & push_ready_out
- pop_fire = pop_ready_in & top_valid_out
- Priority each cycle: clear_in, then the push/pop case table.
- clear_in=1: count<=0, top<=0, overflow<=0, underflow<=0. Push and pop are ignored that cycle and no flag is set.
- Push only: if count>0, mem[count-1]<=top. Then top<=push_data_in and count<=count+1.
- Pop only: if count>=2, top<=mem[count-2]. If count==1, top<=0. In both cases count<=count-1.
- Push and pop together (replace): top<=push_data_in. count and mem are unchanged.
- Neither: hold.
- overflow<=1 when push_valid_in & full & !clear_in, whether or not a pop is requested. The push is dropped.
- underflow<=1 when pop_ready_in & empty & !clear_in. If push_valid_in is high in the same cycle, the push still fires.
- Flags stay set until clear_in or reset.

## Timing
- Reset (rst_in low, asynchronous) forces: count=0, top=0, top_out=0, top_valid_out=0, push_ready_out=1, count_out=0, overflow_out=0, underflow_out=0. Reset overrides any in-flight operation; the next cycle after release is a clean empty stack.
- Push latency: data accepted at edge N appears on top_out, with top_valid_out=1, after edge N. It is visible to the CPU on cycle N+1.
- Pop latency: pop at edge N exposes the next-lower word on top_out after edge N. The CPU samples top_out during the pop cycle itself, i.e. the value before the edge.
- Handshake per edge:
  - One push maximum and one pop maximum.
  - A push while full is not accepted, even with a simultaneous pop. Replace is only possible when not full.
  - No combinational path exists from any input to any output.
- When full, push_ready_out stays low; one pop raises it on the next cycle.
- Throughput: one push or one pop per cycle, sustained.

## Test plan
- Push 3 words: push 0xA, 0xB, 0xC on consecutive cycles. Then count_out=3, top_out=0xC. Pop 3 times: top_out reads 0xC, 0xB, 0xA during each pop cycle. Afterwards top_out=0, top_valid_out=0, underflow_out=0.
- Fill then overflow (DEPTH=16): push values 1..16, so count_out=16 and push_ready_out=0. Push 17 with push_valid_in=1: it is dropped, overflow_out=1, top_out stays 16. One pop: push_ready_out=1 next cycle, top_out=15.
- Replace: with stack [5,6], assert push 9 and pop together. Result: count_out=2, top_out=9. A following pop gives top_out=5.
- Underflow: on an empty stack assert pop_ready_in=1 alone. Result: underflow_out=1, count_out=0. Then push 7 and pop together while empty: push fires, count_out=1, top_out=7.
- Clear priority: with stack [1,2,3], assert clear_in together with a push of 4. Result: count_out=0, top_out=0, both flags 0, and the push is ignored.
- Async reset mid-operation: drop rst_in between clock edges while count=5. All outputs take their reset values immediately, without waiting for a clock edge. After release, push 0x55: top_out=0x55, count_out=1.
